// File: rtl/seq_pkg.sv
// Shared definitions for the ALU issue sequencer: FSM states, the LDI
// opcode and the bit positions of the 16-bit instruction fields.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } seq_state_e;

    localparam int INSTR_W = 16;
    localparam int AW      = 3;

    localparam logic [3:0] OP_LDI = 4'hF;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int RT_HI  = 5;
    localparam int RT_LO  = 3;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Opcode field of an instruction word
    function automatic logic [3:0] f_op(input logic [INSTR_W-1:0] w);
        return w[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// RN x DW register file: one synchronous write port, three combinational
// read ports (two operand reads plus a debug read). Addresses beyond RN
// read as zero and ignore writes.
module seq_regfile
    import seq_pkg::*;
#(
    parameter int DW = 8,
    parameter int RN = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_rs_addr,
    input  logic [AW-1:0] i_rt_addr,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_rs_data,
    output logic [DW-1:0] o_rt_data,
    output logic [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [RN];

    // Register storage: cleared on reset, single write port otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RN; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
        end else if (i_we && (int'(i_waddr) < RN)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read ports with out-of-range protection
    always_comb begin
        o_rs_data  = {DW{1'b0}};
        o_rt_data  = {DW{1'b0}};
        o_dbg_data = {DW{1'b0}};
        if (int'(i_rs_addr) < RN) begin
            o_rs_data = r_mem[i_rs_addr];
        end else begin
            o_rs_data = {DW{1'b0}};
        end
        if (int'(i_rt_addr) < RN) begin
            o_rt_data = r_mem[i_rt_addr];
        end else begin
            o_rt_data = {DW{1'b0}};
        end
        if (int'(i_dbg_addr) < RN) begin
            o_dbg_data = r_mem[i_dbg_addr];
        end else begin
            o_dbg_data = {DW{1'b0}};
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Control stage in front of the 8-bit ALU. Accepts one instruction at a
// time, issues it to the ALU for a single cycle, waits ALU_LAT edges and
// writes the result back; LDI writes its immediate without the ALU.
module alu_issue_sequencer
    import seq_pkg::*;
#(
    parameter int DW      = 8,
    parameter int RN      = 8,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [3:0]         alu_op,
    output logic               alu_en,
    input  logic [DW-1:0]      alu_ans,
    input  logic [3:0]         alu_fl,
    output logic [3:0]         flags,
    output logic               busy,
    output logic               done,
    input  logic [AW-1:0]      dbg_addr,
    output logic [DW-1:0]      dbg_data
);

    seq_state_e         r_state;
    seq_state_e         w_next;
    logic [INSTR_W-1:0] r_instr;
    logic [2:0]         r_count;
    logic [DW-1:0]      r_alu_a;
    logic [DW-1:0]      r_alu_b;
    logic [3:0]         r_alu_op;
    logic               r_alu_en;
    logic [3:0]         r_flags;
    logic               r_done;

    logic               w_accept;
    logic               w_in_ldi;
    logic               w_we;
    logic               w_flag_we;
    logic [DW-1:0]      w_wdata;
    logic [DW-1:0]      w_imm_ext;
    logic [DW-1:0]      w_rs_data;
    logic [DW-1:0]      w_rt_data;

    assign w_in_ldi  = (f_op(instr) == OP_LDI);
    assign w_imm_ext = DW'(r_instr[IMM_HI:IMM_LO]);

    // Operands are fetched from the incoming word at acceptance so they are
    // already registered on the ALU inputs for the whole ISSUE cycle.
    seq_regfile #(
        .DW (DW),
        .RN (RN)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_instr[RD_HI:RD_LO]),
        .i_wdata    (w_wdata),
        .i_rs_addr  (instr[RS_HI:RS_LO]),
        .i_rt_addr  (instr[RT_HI:RT_LO]),
        .i_dbg_addr (dbg_addr),
        .o_rs_data  (w_rs_data),
        .o_rt_data  (w_rt_data),
        .o_dbg_data (dbg_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus write-back strobe and data selection
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_we      = 1'b0;
        w_flag_we = 1'b0;
        w_wdata   = alu_ans;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_accept = 1'b1;
                    if (w_in_ldi) begin
                        w_next = ST_WB;
                    end else begin
                        w_next = ST_ISSUE;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_count == 3'd1) begin
                    w_next    = ST_IDLE;
                    w_we      = 1'b1;
                    w_flag_we = 1'b1;
                    w_wdata   = alu_ans;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WB: begin
                w_next  = ST_IDLE;
                w_we    = 1'b1;
                w_wdata = w_imm_ext;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the accepted instruction for rd/imm use during write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= {INSTR_W{1'b0}};
        end else if (w_accept) begin
            r_instr <= instr;
        end
    end

    // ALU drive registers: loaded at acceptance, held until the next issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= {DW{1'b0}};
            r_alu_b  <= {DW{1'b0}};
            r_alu_op <= 4'h0;
            r_alu_en <= 1'b0;
        end else begin
            r_alu_en <= w_accept && !w_in_ldi;
            if (w_accept && !w_in_ldi) begin
                r_alu_a  <= w_rs_data;
                r_alu_b  <= w_rt_data;
                r_alu_op <= f_op(instr);
            end
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 3'd0;
        end else if (r_state == ST_ISSUE) begin
            r_count <= 3'(ALU_LAT);
        end else if (r_state == ST_WAIT) begin
            r_count <= r_count - 3'd1;
        end
    end

    // Flag capture on ALU write-back and the one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'h0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_we;
            if (w_flag_we) begin
                r_flags <= alu_fl;
            end
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = !instr_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign alu_en      = r_alu_en;
    assign flags       = r_flags;
    assign done        = r_done;

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Upstream control stage for the 8-bit ALU: accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's A/B/opcode/En inputs for one issue cycle, waits the ALU latency, then writes ANS back to the destination register and latches FL into a flag register.
- Also executes load-immediate locally, without using the ALU.

Parameters:
DW, 8, data/register width (matches ALU A/B/ANS)
RN, 8, number of general registers (address width fixed at 3)
ALU_LAT, 1, clock edges from the ALU sampling En=1 to ANS/FL valid (range 1..7)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word present
instr  in  16  [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [7:0] imm (LDI only)
instr_ready  out  1  sequencer can accept an instruction
alu_a  out  DW  ALU operand A = R[rs]
alu_b  out  DW  ALU operand B = R[rt]
alu_op  out  4  ALU opcode
alu_en  out  1  ALU enable, one-cycle pulse per issued op
alu_ans  in  DW  ALU result
alu_fl  in  4  ALU flags
flags  out  4  last captured ALU flags
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse after each register write
dbg_addr  in  3  debug read address
dbg_data  out  DW  combinational read of R[dbg_addr]

Behaviour:
- Reset (rst_n low, asynchronous): all R[i]=0, flags=0, state=IDLE, alu_en=0, alu_a=alu_b=0, alu_op=0, done=0, count=0.
  - Reset mid-operation aborts the instruction. No register or flag write occurs.
- States: IDLE, ISSUE, WAIT, WB.
  - instr_ready = (state==IDLE), combinational.
  - busy = !instr_ready.
- IDLE: on instr_valid & instr_ready, latch instr.
  - op==4'hF (OP_LDI): go to WB.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle): alu_a=R[rs], alu_b=R[rt], alu_op=op, alu_en=1. Load count=ALU_LAT, go to WAIT.
  - alu_a/alu_b/alu_op are registered outputs, valid for the whole ISSUE cycle and held stable through WAIT.
- WAIT: alu_en=0; count decrements every edge.
  - On the edge where count==1: R[rd] <= alu_ans, flags <= alu_fl, done <= 1, go to IDLE.
  - WAIT therefore lasts ALU_LAT cycles.
- WB (1 cycle, LDI only): on exit, R[rd] <= imm[7:0], done <= 1, go to IDLE. Flags are unchanged.
- done is high for exactly the first IDLE cycle after a write. An instruction may be accepted in that same cycle.
- Occupancy per instruction: ALU op = 2 + ALU_LAT cycles; LDI = 2 cycles.
- Operands are read in ISSUE from current contents. Execution is strictly serial, so no hazards exist.
  - rd may equal rs and/or rt.
- dbg_data reflects a write starting the cycle after the write edge.
- instr is ignored whenever instr_ready=0. An instruction held valid across busy cycles is accepted exactly once, at the next IDLE cycle.
- Opcodes 4'h0..4'hE pass unmodified to the ALU. The sequencer does not interpret ALU semantics.
- Width: register file and operands are DW bits. LDI with DW>8 zero-extends imm.

Decomposition:
- Package seq_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, WB)
  - OP_LDI=4'hF
  - field bit positions for op/rd/rs/rt/imm
  - instruction width 16
- One sub-module, seq_regfile: RN x DW with async active-low reset, 1 write port, 3 combinational read ports (rs, rt, dbg).
- The FSM, counter and output registers live in alu_issue_sequencer.

Test Plan:
- Bench ALU model: registered, latency ALU_LAT; op 4'h1: ANS=A+B, FL[0]=carry, FL[1]=zero.
- Reset: hold rst_n=0 with random inputs -> all dbg reads 0, flags=0, alu_en=0, instr_ready=1 after release.
- LDI r1,4 then LDI r2,3 -> done 2 cycles after each accept; dbg r1=4, r2=3; flags unchanged at 0.
- op1 rd=3 rs=1 rt=2 -> ISSUE shows alu_a=4, alu_b=3, alu_op=1, alu_en high for 1 cycle; r3=7, flags=4'b0000; done 3 cycles after accept (ALU_LAT=1).
- r1=8'hFF via LDI, then op1 rd=1 rs=1 rt=1 -> r1=8'hFE, flags[0]=1; instr_valid held high across three back-to-back instructions -> each accepted once, instr_ready low during ISSUE/WAIT.
- rst_n pulsed low during WAIT of op1 rd=4 -> r4 stays 0, done never pulses, state IDLE, alu_en=0.
- ALU_LAT=3 build -> alu_a/alu_b/alu_op held for 3 WAIT cycles; capture on the third; done 5 cycles after accept.
